// File: rtl/sprite_dec_pkg.sv
// Shared sprite-decoder types: CCL fetch states and group geometry.
// Used by the fetch controller, Byte_buf and the CCL decoder.
package sprite_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } ccl_state_e;

  localparam int unsigned CCL_NBYTES = 4;
  localparam int unsigned CCL_ADDR_W = 2;
  localparam int unsigned CCL_SQ_W   = 30;

endpackage

// File: rtl/ccl_stall_wdog.sv
// Stall watchdog: counts starved fetch cycles, fires on the TIMEOUT-th.
// TIMEOUT of zero never fires.
module ccl_stall_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] stall;

  assign expire = (TIMEOUT != 0) && inc &&
                  (stall == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall <= '0;
    end else if (clr || expire) begin
      stall <= '0;
    end else if (inc) begin
      stall <= stall + 1'b1;
    end
  end

endmodule

// File: rtl/ccl_fetch_ctrl.sv
// CCL header fetch: streams NBYTES bytes into Byte_buf, then holds
// ccl_valid until the decoder acks. Starved fetches abort with err.
module ccl_fetch_ctrl
  import sprite_dec_pkg::*;
#(
  parameter int unsigned NBYTES  = CCL_NBYTES,
  parameter int unsigned ADDR_W  = CCL_ADDR_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              buf_enb,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_byte,
  output logic              ccl_valid,
  input  logic              ccl_ack,
  output logic              busy,
  output logic              err
);

  ccl_state_e        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              in_ready_n;
  logic              buf_enb_n;
  logic [ADDR_W-1:0] buf_addr_n;
  logic [7:0]        buf_byte_n;
  logic              ccl_valid_n;
  logic              err_n;

  logic accept;
  logic last;
  logic wd_clr;
  logic wd_inc;
  logic wd_expire;

  assign busy   = (state != IDLE);
  assign accept = (state == FETCH) && in_valid && in_ready;
  assign last   = (cnt == ADDR_W'(NBYTES - 1));
  assign wd_inc = (state == FETCH) && !in_valid;
  assign wd_clr = (state != FETCH) || accept || abort;

  ccl_stall_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    in_ready_n  = in_ready;
    buf_enb_n   = 1'b0;
    buf_addr_n  = buf_addr;
    buf_byte_n  = buf_byte;
    ccl_valid_n = ccl_valid;
    err_n       = err;
    if (abort) begin
      state_n     = IDLE;
      in_ready_n  = 1'b0;
      ccl_valid_n = 1'b0;
      cnt_n       = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n    = FETCH;
            cnt_n      = '0;
            err_n      = 1'b0;
            in_ready_n = 1'b1;
          end
        end
        FETCH: begin
          if (accept) begin
            buf_enb_n  = 1'b1;
            buf_addr_n = cnt;
            buf_byte_n = in_byte;
            if (last) begin
              state_n    = FLUSH;
              in_ready_n = 1'b0;
              cnt_n      = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else if (wd_expire) begin
            state_n    = IDLE;
            err_n      = 1'b1;
            in_ready_n = 1'b0;
            cnt_n      = '0;
          end
        end
        FLUSH: begin
          state_n     = HOLD;
          ccl_valid_n = 1'b1;
        end
        HOLD: begin
          if (ccl_ack) begin
            state_n     = IDLE;
            ccl_valid_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      buf_enb   <= 1'b0;
      buf_addr  <= '0;
      buf_byte  <= '0;
      ccl_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      in_ready  <= in_ready_n;
      buf_enb   <= buf_enb_n;
      buf_addr  <= buf_addr_n;
      buf_byte  <= buf_byte_n;
      ccl_valid <= ccl_valid_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_ccl_fetch_ctrl.sv
// Bench for ccl_fetch_ctrl: scoreboarded Byte_buf writes plus
// handshake, hold, watchdog, abort and async-reset checks.
module tb_ccl_fetch_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic       buf_enb;
  logic [1:0] buf_addr;
  logic [7:0] buf_byte;
  logic       ccl_valid;
  logic       ccl_ack = 1'b0;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;
  int idx   = 0;
  int wr_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ccl_fetch_ctrl #(
    .NBYTES  (4),
    .ADDR_W  (2),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .buf_enb   (buf_enb),
    .buf_addr  (buf_addr),
    .buf_byte  (buf_byte),
    .ccl_valid (ccl_valid),
    .ccl_ack   (ccl_ack),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && buf_enb) begin
      logic [15:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("extra_wr", 32'(buf_addr), 32'hffff);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(buf_addr), 32'(e[15:8]));
        chk("wr_byte", 32'(buf_byte), 32'(e[7:0]));
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    chk("st_busy", 32'(busy), 1);
    chk("st_rdy", 32'(in_ready), 1);
    chk("st_err", 32'(err), 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("gap_rdy", 32'(in_ready), 1);
    end
    in_valid = 1'b1;
    in_byte  = b;
    chk("snd_rdy", 32'(in_ready), 1);
    exp_q.push_back({8'(idx), b});
    idx++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_grp(input logic [31:0] g, input int gap);
    logic [31:0] v;
    v = g;
    for (int i = 0; i < 4; i++)
      send(v[31-8*i -: 8], gap);
  endtask

  task automatic do_ack();
    ccl_ack = 1'b1;
    @(negedge clk);
    ccl_ack = 1'b0;
    chk("ack_vld", 32'(ccl_valid), 0);
    chk("ack_busy", 32'(busy), 0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_rdy"}, 32'(in_ready), 0);
    chk({tag, "_enb"}, 32'(buf_enb), 0);
    chk({tag, "_addr"}, 32'(buf_addr), 0);
    chk({tag, "_byte"}, 32'(buf_byte), 0);
    chk({tag, "_vld"}, 32'(ccl_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  initial begin
    #1;
    chk_rst("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_rst("post_rst");

    // 1: back-to-back group
    do_start();
    wr_cnt = 0;
    send_grp(32'hda8e85c0, 0);
    chk("t1_vld0", 32'(ccl_valid), 0);
    @(negedge clk);
    chk("t1_vld1", 32'(ccl_valid), 1);
    chk("t1_wrs", 32'(wr_cnt), 4);
    do_ack();

    // 2: gapped group
    do_start();
    wr_cnt = 0;
    send_grp(32'hda8e85c0, 3);
    @(negedge clk);
    chk("t2_vld", 32'(ccl_valid), 1);
    chk("t2_wrs", 32'(wr_cnt), 4);
    do_ack();

    // 3: long hold, in_valid ignored
    do_start();
    send_grp(32'h11223344, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_byte  = 8'(8'hA0 + i);
      @(negedge clk);
      chk("t3_vld", 32'(ccl_valid), 1);
      chk("t3_rdy", 32'(in_ready), 0);
      chk("t3_busy", 32'(busy), 1);
    end
    in_valid = 1'b0;
    do_ack();
    chk("t3_q", 32'(exp_q.size()), 0);

    // 4: watchdog
    do_start();
    send(8'h5a, 0);
    send(8'h3c, 0);
    repeat (TO - 1) @(negedge clk);
    chk("t4_err0", 32'(err), 0);
    chk("t4_busy0", 32'(busy), 1);
    @(negedge clk);
    chk("t4_err1", 32'(err), 1);
    chk("t4_busy1", 32'(busy), 0);
    chk("t4_rdy", 32'(in_ready), 0);
    repeat (3) @(negedge clk);
    chk("t4_vld", 32'(ccl_valid), 0);
    chk("t4_hold", 32'(err), 1);
    do_start();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_q", 32'(exp_q.size()), 0);

    // 5: abort after third accept
    do_start();
    wr_cnt = 0;
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'h04;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_rdy", 32'(in_ready), 0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t5_wrs", 32'(wr_cnt), 3);
    chk("t5_vld", 32'(ccl_valid), 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t5_sa_busy", 32'(busy), 0);
    chk("t5_sa_rdy", 32'(in_ready), 0);

    // 6: async reset mid-fetch
    do_start();
    send(8'hee, 0);
    send(8'hff, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("t6");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    send_grp(32'hc0ffee42, 0);
    @(negedge clk);
    chk("t6_vld", 32'(ccl_valid), 1);
    do_ack();
    chk("t6_q", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
